// File: rtl/simpletest_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : simpletest_operand_stage
// Description : Operand staging FIFO feeding the simpletest datapath.
//               Accepts (in1, in2, sel, key_in) over valid/ready, routes the
//               operand pair according to sel at enqueue time (pass, swap,
//               broadcast in1, broadcast in2), buffers up to DEPTH routed
//               pairs and presents the head entry first-word-fall-through.
//
// Ports       :
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      upstream pair valid
//   in_ready   out  1      stage can accept (count != DEPTH)
//   sel        in   2      routing select, stored with the pair
//   in1, in2   in   WIDTH  operands
//   key_in     in   1      key bit stored with the pair
//   out_valid  out  1      head entry present (count != 0)
//   out_ready  in   1      datapath consumes head
//   op1, op2   out  WIDTH  head entry routed operands (0 when empty)
//   sel_r      out  2      head entry sel as captured (0 when empty)
//   key        out  1      head entry key (0 when empty)
//   count      out  CW     occupancy, 0..DEPTH
//
// Revision    : 1.0 - initial release
// ============================================================================
module simpletest_operand_stage #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic [1:0]       sel_r,
    output logic             key,
    output logic [CW-1:0]    count
);

    localparam int            c_aw    = $clog2(DEPTH);
    localparam logic [CW-1:0] c_full  = CW'(DEPTH);
    localparam logic [CW-1:0] c_empty = '0;

    localparam logic [1:0] c_sel_pass  = 2'b00;
    localparam logic [1:0] c_sel_swap  = 2'b01;
    localparam logic [1:0] c_sel_bcst1 = 2'b10;
    localparam logic [1:0] c_sel_bcst2 = 2'b11;

    // ------------------------------------------------------------------
    // Storage: no reset on the array, only pointers and occupancy.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem_op1 [DEPTH];
    logic [WIDTH-1:0] r_mem_op2 [DEPTH];
    logic [1:0]       r_mem_sel [DEPTH];
    logic             r_mem_key [DEPTH];

    logic [c_aw-1:0]  r_wp;
    logic [c_aw-1:0]  r_rp;
    logic [CW-1:0]    r_count;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_route_op1;
    logic [WIDTH-1:0] w_route_op2;

    // Handshake flags depend only on registered occupancy, so there is no
    // combinational path from in_valid/out_ready back to the ready/valid.
    assign w_in_ready  = (r_count != c_full);
    assign w_out_valid = (r_count != c_empty);

    // An empty FIFO cannot pop and a full FIFO cannot push, so a same-cycle
    // push into empty lands in storage and appears one cycle later.
    assign w_push = in_valid  && w_in_ready;
    assign w_pop  = w_out_valid && out_ready;

    // ------------------------------------------------------------------
    // Enqueue-side routing of the operand pair.
    // ------------------------------------------------------------------
    always_comb begin
        w_route_op1 = in1;
        w_route_op2 = in2;
        case (sel)
            c_sel_pass: begin
                w_route_op1 = in1;
                w_route_op2 = in2;
            end
            c_sel_swap: begin
                w_route_op1 = in2;
                w_route_op2 = in1;
            end
            c_sel_bcst1: begin
                w_route_op1 = in1;
                w_route_op2 = in1;
            end
            c_sel_bcst2: begin
                w_route_op1 = in2;
                w_route_op2 = in2;
            end
            default: begin
                w_route_op1 = in1;
                w_route_op2 = in2;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage write. Reset gating keeps a push in the reset cycle from
    // landing, although it would be unreachable anyway once pointers clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_op1[r_wp] <= w_route_op1;
            r_mem_op2[r_wp] <= w_route_op2;
            r_mem_sel[r_wp] <= sel;
            r_mem_key[r_wp] <= key_in;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy. DEPTH is a power of two, so the pointers
    // wrap naturally through their log2(DEPTH)-bit width.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + c_aw'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Head presentation: forced to zero when empty so stale array contents
    // never reach the datapath.
    // ------------------------------------------------------------------
    always_comb begin
        op1   = '0;
        op2   = '0;
        sel_r = '0;
        key   = 1'b0;
        if (w_out_valid) begin
            op1   = r_mem_op1[r_rp];
            op2   = r_mem_op2[r_rp];
            sel_r = r_mem_sel[r_rp];
            key   = r_mem_key[r_rp];
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_simpletest_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_simpletest_operand_stage
// Description : Self-checking bench for simpletest_operand_stage. A queue of
//               raw (unrouted) pairs is the reference; routing is applied
//               when the head is compared. Directed scenarios are followed
//               by a randomized phase with occasional resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simpletest_operand_stage;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       sel;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             key_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [1:0]       sel_r;
    logic             key;
    logic [CW-1:0]    count;

    simpletest_operand_stage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .in1       (in1),
        .in2       (in2),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op1       (op1),
        .op2       (op2),
        .sel_r     (sel_r),
        .key       (key),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       s;
        logic             k;
    } pair_t;

    pair_t q_model[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Routing rule applied to a raw pair: returns {op1, op2}.
    function automatic logic [2*WIDTH-1:0] routed(input pair_t p);
        case (p.s)
            2'd0:    return {p.a, p.b};
            2'd1:    return {p.b, p.a};
            2'd2:    return {p.a, p.a};
            default: return {p.b, p.b};
        endcase
    endfunction

    // One clock: compare DUT to model mid-cycle, then advance the model
    // with the inputs present at the rising edge.
    task automatic step();
        logic [2*WIDTH-1:0] r;
        bit do_push;
        bit do_pop;
        @(negedge clk);
        check_value("count",    32'(count),    32'(q_model.size()));
        check_value("in_ready", 32'(in_ready), 32'(q_model.size() < DEPTH));
        check_value("out_valid",32'(out_valid),32'(q_model.size() > 0));
        if (q_model.size() > 0) begin
            r = routed(q_model[0]);
            check_value("op1",   32'(op1),   32'(r[2*WIDTH-1:WIDTH]));
            check_value("op2",   32'(op2),   32'(r[WIDTH-1:0]));
            check_value("sel_r", 32'(sel_r), 32'(q_model[0].s));
            check_value("key",   32'(key),   32'(q_model[0].k));
        end else begin
            check_value("op1_empty", 32'(op1),   32'h0);
            check_value("op2_empty", 32'(op2),   32'h0);
            check_value("sel_empty", 32'(sel_r), 32'h0);
            check_value("key_empty", 32'(key),   32'h0);
        end
        @(posedge clk);
        if (rst) begin
            q_model.delete();
        end else begin
            do_pop  = (q_model.size() > 0) && out_ready;
            do_push = in_valid && (q_model.size() < DEPTH);
            if (do_pop)  void'(q_model.pop_front());
            if (do_push) q_model.push_back('{a: in1, b: in2, s: sel, k: key_in});
        end
        #1;
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b,
                             input logic [1:0] s, input logic k);
        in_valid = 1'b1;
        in1      = a;
        in2      = b;
        sel      = s;
        key_in   = k;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_r1 [4];
        logic [7:0] exp_r2 [4];
        exp_r1 = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
        exp_r2 = '{8'h3C, 8'hA5, 8'hA5, 8'h3C};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = 2'b00;
        in1       = '0;
        in2       = '0;
        key_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q_model.delete();
        rst = 1'b0;

        // Reset state and a single pair held until consumed.
        check_value("rst_count",     32'(count),     32'd0);
        check_value("rst_in_ready",  32'(in_ready),  32'd1);
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        push_pair(8'h12, 8'h34, 2'b00, 1'b1);
        check_value("single_valid", 32'(out_valid), 32'd1);
        check_value("single_op1",   32'(op1),       32'h12);
        check_value("single_op2",   32'(op2),       32'h34);
        check_value("single_key",   32'(key),       32'd1);
        check_value("single_count", 32'(count),     32'd1);
        repeat (3) step();
        check_value("hold_op1", 32'(op1), 32'h12);
        check_value("hold_op2", 32'(op2), 32'h34);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_value("single_drained", 32'(count), 32'd0);

        // Routing of all four selects.
        for (int i = 0; i < 4; i++) push_pair(8'hA5, 8'h3C, 2'(i), 1'(i));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_value("route_op1", 32'(op1),   32'(exp_r1[i]));
            check_value("route_op2", 32'(op2),   32'(exp_r2[i]));
            check_value("route_sel", 32'(sel_r), 32'(i));
            step();
        end
        out_ready = 1'b0;

        // Full, back-pressure, then wrap.
        for (int i = 1; i <= 4; i++) push_pair(8'(8'h10 + i), 8'(8'h20 + i), 2'b00, 1'b0);
        in_valid = 1'b1;
        in1      = 8'h15;
        in2      = 8'h25;
        sel      = 2'b00;
        repeat (2) step();
        check_value("full_count", 32'(count),    32'd4);
        check_value("full_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        check_value("after_pop_count", 32'(count),    32'd3);
        check_value("after_pop_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check_value("fifth_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check_value("wrap_op1", 32'(op1), 32'(8'h10 + i));
            step();
        end
        out_ready = 1'b0;

        // Sustained simultaneous push/pop at count 2.
        push_pair(8'h01, 8'h02, 2'b01, 1'b0);
        push_pair(8'h03, 8'h04, 2'b10, 1'b1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in1    = 8'($urandom);
            in2    = 8'($urandom);
            sel    = 2'($urandom);
            key_in = 1'($urandom);
            step();
            check_value("stream_count", 32'(count), 32'd2);
        end
        out_ready = 1'b0;
        repeat (2) step();
        in_valid = 1'b0;
        check_value("refill_count", 32'(count), 32'd4);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        check_value("full_both_count", 32'(count), 32'd3);
        in_valid = 1'b0;
        repeat (3) step();

        // Pop request while empty.
        repeat (3) step();
        check_value("empty_pop_count", 32'(count), 32'd0);
        check_value("empty_pop_op1",   32'(op1),   32'd0);
        out_ready = 1'b0;

        // Reset mid-operation with a concurrent push.
        for (int i = 0; i < 3; i++) push_pair(8'(8'h40 + i), 8'h55, 2'b00, 1'b1);
        rst      = 1'b1;
        in_valid = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_value("midrst_count", 32'(count),     32'd0);
        check_value("midrst_valid", 32'(out_valid), 32'd0);
        step();
        check_value("midrst_discard", 32'(count), 32'd0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 50);
            in1       = 8'($urandom);
            in2       = 8'($urandom);
            sel       = 2'($urandom);
            key_in    = 1'($urandom);
            step();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
